// File: rtl/maze_grid_tracker.sv
// Maze occupancy tracker: records robot tile visits from position packets and
// renders the per-tile state as a colour for each VGA pixel.
module maze_grid_tracker #(
    parameter int unsigned ROWS    = 4,
    parameter int unsigned COLS    = 5,
    parameter int unsigned TILE_PX = 50
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       PKT_VALID,
    input  logic [3:0] PKT_ROW,
    input  logic [3:0] PKT_COL,
    output logic       PKT_READY,
    input  logic [9:0] PIXEL_X,
    input  logic [9:0] PIXEL_Y,
    output logic [7:0] PIXEL_COLOR,
    output logic [7:0] VISITED_COUNT,
    output logic       ALL_VISITED,
    output logic       PKT_ERR
);

    localparam int unsigned NT = ROWS * COLS;
    localparam int unsigned IW = $clog2(NT);
    localparam int unsigned CW = $clog2(NT + 1);

    localparam logic [1:0] T_UNVISITED = 2'b00;
    localparam logic [1:0] T_VISITED   = 2'b01;
    localparam logic [1:0] T_CURRENT   = 2'b10;

    localparam logic [7:0] C_UNVISITED = 8'b111_000_00;
    localparam logic [7:0] C_VISITED   = 8'b000_000_11;
    localparam logic [7:0] C_CURRENT   = 8'b000_111_00;
    localparam logic [7:0] C_OUTSIDE   = 8'b000_000_00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEMOTE = 2'd1,
        MARK   = 2'd2
    } state_e;

    state_e          state_q;
    logic [1:0]      tile_q [NT];
    logic [IW-1:0]   cap_idx_q;
    logic [IW-1:0]   cur_idx_q;
    logic            cur_vld_q;
    logic [CW-1:0]   count_q;
    logic            err_q;
    logic [7:0]      color_q;

    logic            pkt_in_range_c;
    logic [IW-1:0]   pkt_idx_c;
    logic [9:0]      pix_col_c;
    logic [9:0]      pix_row_c;
    logic            pix_in_grid_c;
    logic [IW-1:0]   pix_idx_c;
    logic [7:0]      color_d;

    // Packet decode: range check and flattened tile index
    always_comb begin
        pkt_in_range_c = (32'(PKT_ROW) < ROWS) && (32'(PKT_COL) < COLS);
        pkt_idx_c      = '0;
        if (pkt_in_range_c) begin
            pkt_idx_c = IW'(32'(PKT_ROW) * COLS + 32'(PKT_COL));
        end
    end

    // Update FSM; a tile write happens only in DEMOTE and MARK
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cap_idx_q <= '0;
            cur_idx_q <= '0;
            cur_vld_q <= 1'b0;
            count_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < int'(NT); i++) begin
                tile_q[i] <= T_UNVISITED;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (PKT_VALID) begin
                        if (pkt_in_range_c) begin
                            cap_idx_q <= pkt_idx_c;
                            state_q   <= DEMOTE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DEMOTE: begin
                    if (cur_vld_q) begin
                        tile_q[cur_idx_q] <= T_VISITED;
                    end
                    state_q <= MARK;
                end
                MARK: begin
                    tile_q[cap_idx_q] <= T_CURRENT;
                    if (tile_q[cap_idx_q] == T_UNVISITED && count_q != CW'(NT)) begin
                        count_q <= count_q + CW'(1);
                    end
                    cur_idx_q <= cap_idx_q;
                    cur_vld_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pixel to tile mapping; reads the array before any same-edge write
    always_comb begin
        pix_col_c     = 10'(PIXEL_X / 10'(TILE_PX));
        pix_row_c     = 10'(PIXEL_Y / 10'(TILE_PX));
        pix_in_grid_c = (32'(pix_col_c) < COLS) && (32'(pix_row_c) < ROWS);
        pix_idx_c     = '0;
        color_d       = C_OUTSIDE;
        if (pix_in_grid_c) begin
            pix_idx_c = IW'(32'(pix_row_c) * COLS + 32'(pix_col_c));
            case (tile_q[pix_idx_c])
                T_UNVISITED: color_d = C_UNVISITED;
                T_VISITED:   color_d = C_VISITED;
                T_CURRENT:   color_d = C_CURRENT;
                default:     color_d = C_OUTSIDE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            color_q <= C_OUTSIDE;
        end else begin
            color_q <= color_d;
        end
    end

    assign PKT_READY     = (state_q == IDLE);
    assign PIXEL_COLOR   = color_q;
    assign VISITED_COUNT = 8'(count_q);
    assign ALL_VISITED   = (count_q == CW'(NT));
    assign PKT_ERR       = err_q;

endmodule

// File: tb/tb_maze_grid_tracker.sv
// Scoreboard bench for maze_grid_tracker: a tile-level reference model predicts
// pixel colours and status; a monitor pops expected colours and compares.
module tb_maze_grid_tracker;

    localparam int ROWS    = 4;
    localparam int COLS    = 5;
    localparam int TILE_PX = 50;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       PKT_VALID = 1'b0;
    logic [3:0] PKT_ROW = '0;
    logic [3:0] PKT_COL = '0;
    logic       PKT_READY;
    logic [9:0] PIXEL_X = '0;
    logic [9:0] PIXEL_Y = '0;
    logic [7:0] PIXEL_COLOR;
    logic [7:0] VISITED_COUNT;
    logic       ALL_VISITED;
    logic       PKT_ERR;

    maze_grid_tracker #(.ROWS(ROWS), .COLS(COLS), .TILE_PX(TILE_PX)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .PKT_VALID(PKT_VALID), .PKT_ROW(PKT_ROW), .PKT_COL(PKT_COL), .PKT_READY(PKT_READY),
        .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .PIXEL_COLOR(PIXEL_COLOR),
        .VISITED_COUNT(VISITED_COUNT), .ALL_VISITED(ALL_VISITED), .PKT_ERR(PKT_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0;
    int checks = 0;

    // Reference model: 0 never visited, 1 visited, 2 robot is here
    int mt [ROWS][COLS];
    int m_count;
    bit m_err;
    bit m_has_cur;
    int m_cur_r, m_cur_c;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic       probe_vld = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mt[r, c]) mt[r][c] = 0;
        m_count = 0; m_err = 0; m_has_cur = 0; m_cur_r = 0; m_cur_c = 0;
    endtask

    task automatic model_apply(input int r, input int c);
        if (r >= ROWS || c >= COLS) begin
            m_err = 1;
        end else begin
            if (mt[r][c] == 0 && m_count < ROWS * COLS) m_count++;
            if (m_has_cur) mt[m_cur_r][m_cur_c] = 1;
            mt[r][c] = 2;
            m_has_cur = 1; m_cur_r = r; m_cur_c = c;
        end
    endtask

    function automatic logic [7:0] model_color(input int x, input int y);
        int c = x / TILE_PX;
        int r = y / TILE_PX;
        if (c >= COLS || r >= ROWS) return 8'h00;
        case (mt[r][c])
            0:       return 8'hE0;
            1:       return 8'h03;
            default: return 8'h1C;
        endcase
    endfunction

    // Probe one pixel with a caller-supplied expectation (phase: just after an edge)
    task automatic probe_exp(input int x, input int y, input logic [7:0] exp, input string tag);
        PIXEL_X = 10'(x); PIXEL_Y = 10'(y); probe_vld = 1'b1;
        exp_q.push_back(exp); tag_q.push_back(tag);
        @(posedge CLOCK); #1;
        probe_vld = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input string tag);
        probe_exp(x, y, model_color(x, y), tag);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, int'(VISITED_COUNT), m_count);
        check({tag, "_all"}, int'(ALL_VISITED), int'(m_count == ROWS * COLS));
        check({tag, "_err"}, int'(PKT_ERR), int'(m_err));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!PKT_READY && n < 20) begin @(posedge CLOCK); #1; n++; end
        if (!PKT_READY) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int r, input int c);
        bit inr = (r < ROWS && c < COLS);
        wait_ready();
        PKT_VALID = 1'b1; PKT_ROW = 4'(r); PKT_COL = 4'(c);
        @(posedge CLOCK); #1;
        PKT_VALID = 1'b0;
        check("ready_after_accept", int'(PKT_READY), int'(!inr));
        if (inr) begin
            @(posedge CLOCK); #1;
            check("ready_in_mark", int'(PKT_READY), 0);
            @(posedge CLOCK); #1;
            check("ready_back", int'(PKT_READY), 1);
        end
        model_apply(r, c);
    endtask

    // Monitor: a probe driven before an edge yields a colour sampled at the next falling edge
    initial begin
        bit had;
        logic [7:0] e;
        string t;
        forever begin
            @(posedge CLOCK);
            had = probe_vld;
            @(negedge CLOCK);
            if (had) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check({"pixel_", t}, int'(PIXEL_COLOR), int'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge CLOCK);
        #1;
        check("reset_color", int'(PIXEL_COLOR), 0);
        check_status("reset");
        RESET = 1'b0;
        #1;
        check("ready_after_reset", int'(PKT_READY), 1);
        @(posedge CLOCK); #1;

        // Fresh grid and outside-grid lookup
        probe(10, 10, "fresh_00");
        probe_exp(300, 10, 8'h00, "outside_x");
        probe_exp(10, 10, 8'hE0, "fresh_const");

        send(1, 2);
        probe_exp(120, 60, 8'h1C, "cur_1_2");
        check_status("one_pkt");

        send(0, 0);
        send(0, 1);
        probe_exp(10, 10, 8'h03, "visited_0_0");
        probe_exp(60, 10, 8'h1C, "cur_0_1");
        probe(120, 60, "visited_1_2");
        check_status("three_pkt");
        send(0, 1);
        probe(60, 10, "same_pos");
        check_status("same_pos");

        send(4, 0);
        check("err_set", int'(PKT_ERR), 1);
        probe(60, 10, "after_err");
        check_status("bad_pkt");
        send(1, 7);
        check_status("bad_col");

        // Lookup on the same edge as DEMOTE/MARK writes sees the old state
        wait_ready();
        PKT_VALID = 1'b1; PKT_ROW = 4'd2; PKT_COL = 4'd2;
        @(posedge CLOCK); #1;
        PKT_VALID = 1'b0;
        probe(60, 10, "prewrite_demote");
        probe(120, 120, "prewrite_mark");
        model_apply(2, 2);
        probe(60, 10, "postwrite_demote");
        probe(120, 120, "postwrite_mark");

        // Walk every tile, then revisit
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                send(r, c);
        check("all_count", int'(VISITED_COUNT), 20);
        check("all_flag", int'(ALL_VISITED), 1);
        send(3, 1);
        check("all_revisit", int'(VISITED_COUNT), 20);
        check_status("all");

        // Reset aborting an update in MARK
        wait_ready();
        PKT_VALID = 1'b1; PKT_ROW = 4'd2; PKT_COL = 4'd2;
        @(posedge CLOCK); #1;
        PKT_VALID = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        model_reset();
        #2;
        check("abort_color", int'(PIXEL_COLOR), 0);
        check_status("abort");
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        #1;
        check("abort_ready", int'(PKT_READY), 1);
        @(posedge CLOCK); #1;
        probe_exp(120, 120, 8'hE0, "abort_tile");
        check_status("abort_after");

        // Boundary pixel coordinates
        send(3, 4);
        probe(249, 199, "edge_in");
        probe(250, 199, "edge_x_out");
        probe(249, 200, "edge_y_out");
        probe(1023, 1023, "max_xy");
        probe(0, 0, "origin");

        // Randomised packets and pixel probes
        for (int i = 0; i < 200; i++) begin
            int r, c;
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 15); c = $urandom_range(0, 15);
            end else begin
                r = $urandom_range(0, ROWS - 1); c = $urandom_range(0, COLS - 1);
            end
            send(r, c);
            repeat ($urandom_range(1, 3)) begin
                if ($urandom_range(0, 3) == 0)
                    probe($urandom_range(0, 1023), $urandom_range(0, 1023), "rand_any");
                else
                    probe($urandom_range(0, COLS * TILE_PX - 1),
                          $urandom_range(0, ROWS * TILE_PX - 1), "rand_grid");
            end
            if (i % 20 == 0) check_status("rand");
        end
        check_status("final");

        repeat (3) @(posedge CLOCK);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_grid_tracker.md
MAZE_GRID_TRACKER -- requirements
Module: maze_grid_tracker

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of maze rows (2..16).
REQ-002 SHALL have parameter COLS, default 5, number of maze columns (2..16).
REQ-003 SHALL have parameter TILE_PX, default 50, tile edge length in pixels (ROWS*TILE_PX <= 480, COLS*TILE_PX <= 640).
REQ-004 SHALL have port CLOCK  in  1  single clock for all logic (25 MHz pixel clock).
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port PKT_VALID  in  1  position packet present.
REQ-007 SHALL have port PKT_ROW  in  4  robot row index.
REQ-008 SHALL have port PKT_COL  in  4  robot column index.
REQ-009 SHALL have port PKT_READY  out  1  block can accept a packet this cycle.
REQ-010 SHALL have port PIXEL_X  in  10  current VGA x coordinate.
REQ-011 SHALL have port PIXEL_Y  in  10  current VGA y coordinate.
REQ-012 SHALL have port PIXEL_COLOR  out  8  RRR_GGG_BB colour for the pixel.
REQ-013 SHALL have port VISITED_COUNT  out  8  number of tiles ever occupied.
REQ-014 SHALL have port ALL_VISITED  out  1  high while VISITED_COUNT == ROWS*COLS.
REQ-015 SHALL have port PKT_ERR  out  1  sticky flag: out-of-range packet received.

Function
REQ-016 SHALL store a 2-bit state per tile: UNVISITED=00, VISITED=01, CURRENT=10; code 11 never written.
REQ-017 SHALL implement FSM IDLE -> DEMOTE -> MARK -> IDLE; PKT_READY = 1 only in IDLE.
REQ-018 SHALL accept a packet on a rising CLOCK edge with PKT_VALID & PKT_READY; row/col captured at that edge; next state DEMOTE.
REQ-019 DEMOTE SHALL change the previous CURRENT tile (if any) to VISITED; MARK SHALL set the captured tile to CURRENT; MARK -> IDLE unconditionally.
REQ-020 Packet with PKT_ROW >= ROWS or PKT_COL >= COLS SHALL be consumed (handshake completes), leave FSM in IDLE, change no tile, and set PKT_ERR until reset.
REQ-021 Packet equal to the current position SHALL traverse DEMOTE/MARK and end with the same tile CURRENT; VISITED_COUNT unchanged.
REQ-022 VISITED_COUNT SHALL increment by 1 in MARK only when the target tile was UNVISITED; saturates at ROWS*COLS.
REQ-023 Packet throughput SHALL be at most one per 3 cycles; PKT_VALID while PKT_READY=0 SHALL be ignored (sender holds).
REQ-024 Tile lookup SHALL use col = floor(PIXEL_X/TILE_PX), row = floor(PIXEL_Y/TILE_PX), exact for all 0..1023 inputs.
REQ-025 PIXEL_COLOR SHALL be registered, 1-cycle latency from PIXEL_X/PIXEL_Y: UNVISITED 8'b111_000_00, VISITED 8'b000_000_11, CURRENT 8'b000_111_00, outside grid (col >= COLS or row >= ROWS) 8'b000_000_00.
REQ-026 A pixel lookup on the same edge as a DEMOTE/MARK write SHALL return the pre-write state.
REQ-027 ALL_VISITED SHALL be combinational from VISITED_COUNT.

Reset
REQ-028 RESET high SHALL immediately clear all tiles to UNVISITED, clear "current" to none, VISITED_COUNT=0, PKT_ERR=0, PIXEL_COLOR=0, FSM=IDLE.
REQ-029 RESET asserted in DEMOTE or MARK SHALL abort the update; no partial state survives.
REQ-030 PKT_READY SHALL be 1 on the first edge after RESET deasserts.

Verification
REQ-031 Reset, then pixel (10,10) -> PIXEL_COLOR=8'hE0 next cycle; (300,10) -> 8'h00 (outside, COLS=5).
REQ-032 Packet (row 1,col 2) -> PKT_READY low 2 cycles, then pixel (120,60) -> 8'h1C, VISITED_COUNT=1.
REQ-033 Packets (0,0) then (0,1) -> pixel (10,10) -> 8'h03, (60,10) -> 8'h1C, VISITED_COUNT=2; repeat (0,1) -> count stays 2.
REQ-034 Packet (4,0) with ROWS=4 -> PKT_ERR=1, no tile change, count unchanged, PKT_READY stays 1.
REQ-035 Visit all 20 tiles -> ALL_VISITED=1, VISITED_COUNT=20; extra revisit keeps 20.
REQ-036 RESET during MARK of packet (2,2) -> pixel (120,120) -> 8'hE0, VISITED_COUNT=0, PKT_READY=1 after release.
